// File: rtl/registrador_deslocamento_universal_pkg.sv
// Mode codes shared by the mode mux, the shift register and the pattern controller.
package registrador_deslocamento_universal_pkg;

   typedef logic [1:0] modo_t;

   localparam modo_t MODO_DEFINIR = 2'b00;
   localparam modo_t MODO_DIR_ESQ = 2'b01;
   localparam modo_t MODO_ESQ_DIR = 2'b10;
   localparam modo_t MODO_MANTER  = 2'b11;

   function automatic logic modo_desloca(input modo_t m);
      return (m == MODO_DIR_ESQ) || (m == MODO_ESQ_DIR);
   endfunction

endpackage

// File: rtl/registrador_deslocamento_universal_if.sv
// Control/data bundle of the universal shift register; master drives controls, slave returns the register.
interface registrador_deslocamento_universal_if #(
   parameter int unsigned LARGURA = 8
);
   logic               habilitar;
   logic [1:0]         modo;
   logic [LARGURA-1:0] valores;
   logic               serial_dir;
   logic               serial_esq;
   logic               rotacionar;
   logic [LARGURA-1:0] saida;
   logic               pulso_passo;

   modport master (
      output habilitar, modo, valores, serial_dir, serial_esq, rotacionar,
      input  saida, pulso_passo
   );

   modport slave (
      input  habilitar, modo, valores, serial_dir, serial_esq, rotacionar,
      output saida, pulso_passo
   );
endinterface

// File: rtl/registrador_deslocamento_universal_divisor_passo.sv
// Step prescaler: counts enabled shift-mode cycles and ticks every DIVISOR of them.
module divisor_passo #(
   parameter int unsigned DIVISOR = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       habilitar,
   input  logic [1:0] modo,
   output logic       tick
);
   import registrador_deslocamento_universal_pkg::*;

   localparam int unsigned LARG_CONT = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [LARG_CONT-1:0] ULTIMO = LARG_CONT'(DIVISOR - 1);

   logic [LARG_CONT-1:0] contagem;
   modo_t                modo_ant;
   logic                 mudou;

   assign mudou = (modo != modo_ant);

   always_comb begin
      tick = 1'b0;
      if (habilitar && modo_desloca(modo) && !mudou && (contagem == ULTIMO))
         tick = 1'b1;
   end

   // A mode change restarts the phase so the first step is a full DIVISOR away.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         contagem <= '0;
         modo_ant <= MODO_MANTER;
      end else begin
         modo_ant <= modo;
         if (mudou || !modo_desloca(modo))
            contagem <= '0;
         else if (habilitar)
            contagem <= tick ? '0 : contagem + 1'b1;
      end
   end
endmodule

// File: rtl/registrador_deslocamento_universal.sv
// Clocked universal shift register with step prescaler driving the LED bank.
// Optional macro ROTACAO_EN: rotacionar=1 recirculates the end bit instead of the serial inputs.
module registrador_deslocamento_universal #(
   parameter int unsigned LARGURA = 8,
   parameter int unsigned DIVISOR = 4
) (
   input logic                                  clk,
   input logic                                  rst_n,
   registrador_deslocamento_universal_if.slave  barramento
);
   import registrador_deslocamento_universal_pkg::*;

   logic [LARGURA-1:0] saida_q;
   logic               pulso_q;
   logic               tick;
   logic               entra_lsb;
   logic               entra_msb;

   divisor_passo #(
      .DIVISOR (DIVISOR)
   ) u_divisor_passo (
      .clk       (clk),
      .rst_n     (rst_n),
      .habilitar (barramento.habilitar),
      .modo      (barramento.modo),
      .tick      (tick)
   );

`ifdef ROTACAO_EN
   assign entra_lsb = barramento.rotacionar ? saida_q[LARGURA-1] : barramento.serial_dir;
   assign entra_msb = barramento.rotacionar ? saida_q[0]         : barramento.serial_esq;
`else
   assign entra_lsb = barramento.serial_dir;
   assign entra_msb = barramento.serial_esq;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         saida_q <= '0;
         pulso_q <= 1'b0;
      end else begin
         pulso_q <= 1'b0;
         case (barramento.modo)
            MODO_DEFINIR: saida_q <= barramento.valores;
            MODO_DIR_ESQ: if (tick) begin
               saida_q <= {saida_q[LARGURA-2:0], entra_lsb};
               pulso_q <= 1'b1;
            end
            MODO_ESQ_DIR: if (tick) begin
               saida_q <= {entra_msb, saida_q[LARGURA-1:1]};
               pulso_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign barramento.saida       = saida_q;
   assign barramento.pulso_passo = pulso_q;
endmodule

// File: tb/tb_registrador_deslocamento_universal.sv
// Bench for the universal shift register: DIVISOR=4 and DIVISOR=1 instances against a phase-count model.
module tb_registrador_deslocamento_universal;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       hab;
   logic [1:0] modo;
   logic [7:0] valores;
   logic       sdir;
   logic       sesq;
   logic       rot;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   registrador_deslocamento_universal_if #(.LARGURA(8)) ifa ();
   registrador_deslocamento_universal_if #(.LARGURA(8)) ifb ();

   assign ifa.habilitar  = hab;
   assign ifa.modo       = modo;
   assign ifa.valores    = valores;
   assign ifa.serial_dir = sdir;
   assign ifa.serial_esq = sesq;
   assign ifa.rotacionar = rot;
   assign ifb.habilitar  = hab;
   assign ifb.modo       = modo;
   assign ifb.valores    = valores;
   assign ifb.serial_dir = sdir;
   assign ifb.serial_esq = sesq;
   assign ifb.rotacionar = rot;

   registrador_deslocamento_universal #(.LARGURA(8), .DIVISOR(4)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .barramento (ifa.slave)
   );

   registrador_deslocamento_universal #(.LARGURA(8), .DIVISOR(1)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .barramento (ifb.slave)
   );

   task automatic chk(input string nome, input logic [7:0] dut, input logic [7:0] esperado);
      checks++;
      if (dut !== esperado) begin
         errors++;
         $display("FAIL %s dut=%h expected=%h at %0t", nome, dut, esperado, $time);
      end
   endtask

   // Model: m_fase counts enabled cycles spent in a stable shift mode; the D-th one is a step.
   int unsigned divs [2] = '{4, 1};
   logic [7:0]  m_saida [2];
   logic        m_pulso [2];
   int unsigned m_fase  [2];
   logic [1:0]  m_prev  [2];
   logic        passo;
   int unsigned entra;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_saida[k] = 8'h00;
            m_pulso[k] = 1'b0;
            m_fase[k]  = 0;
            m_prev[k]  = 2'b11;
         end else begin
            passo = 1'b0;
            if (modo == 2'b00) begin
               m_saida[k] = valores;
               m_fase[k]  = 0;
            end else if (modo == 2'b11 || modo != m_prev[k]) begin
               m_fase[k] = 0;
            end else if (hab) begin
               m_fase[k] = m_fase[k] + 1;
               if (m_fase[k] == divs[k]) begin
                  m_fase[k] = 0;
                  passo = 1'b1;
               end
            end
            if (passo && modo == 2'b01) begin
               entra = sdir;
`ifdef ROTACAO_EN
               if (rot) entra = int'(m_saida[k]) / 128;
`endif
               m_saida[k] = 8'((int'(m_saida[k]) * 2 + entra) % 256);
            end else if (passo && modo == 2'b10) begin
               entra = sesq;
`ifdef ROTACAO_EN
               if (rot) entra = int'(m_saida[k]) % 2;
`endif
               m_saida[k] = 8'(int'(m_saida[k]) / 2 + entra * 128);
            end
            m_pulso[k] = passo;
            m_prev[k]  = modo;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("model_saida_div4",  ifa.saida,              m_saida[0]);
      chk("model_pulso_div4",  {7'd0, ifa.pulso_passo}, {7'd0, m_pulso[0]});
      chk("model_saida_div1",  ifb.saida,              m_saida[1]);
      chk("model_pulso_div1",  {7'd0, ifb.pulso_passo}, {7'd0, m_pulso[1]});
   end

   task automatic ciclos(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b0; hab = 1'b0; modo = 2'b00; valores = 8'hFF;
      sdir = 1'b0; sesq = 1'b0; rot = 1'b0;

      // reset with load pending
      ciclos(2);
      chk("reset_saida", ifa.saida, 8'h00);
      chk("reset_pulso", {7'd0, ifa.pulso_passo}, 8'h00);
      rst_n = 1'b1;
      ciclos(1);
      chk("load_ff", ifa.saida, 8'hFF);

      // right-to-left from 01
      valores = 8'h01;
      ciclos(1);
      chk("load_01", ifa.saida, 8'h01);
      modo = 2'b01; sdir = 1'b0; hab = 1'b1;
      ciclos(4);
      chk("r2l_wait", ifa.saida, 8'h01);
      chk("r2l_div1_every_cycle", ifb.saida, 8'h08);
      ciclos(1);
      chk("r2l_step1", ifa.saida, 8'h02);
      chk("r2l_pulse1", {7'd0, ifa.pulso_passo}, 8'h01);
      ciclos(1);
      chk("r2l_pulse_one_cycle", {7'd0, ifa.pulso_passo}, 8'h00);
      ciclos(3);
      chk("r2l_step2", ifa.saida, 8'h04);

      // freeze at count 2
      ciclos(2);
      hab = 1'b0;
      ciclos(6);
      chk("freeze_hold", ifa.saida, 8'h04);
      hab = 1'b1;
      ciclos(1);
      chk("unfreeze_no_step", ifa.saida, 8'h04);
      ciclos(1);
      chk("unfreeze_step", ifa.saida, 8'h08);

      // left-to-right with fill
      modo = 2'b00; valores = 8'h80;
      ciclos(1);
      modo = 2'b10; sesq = 1'b1;
      ciclos(4);
      chk("l2r_wait", ifa.saida, 8'h80);
      ciclos(1);
      chk("l2r_c0", ifa.saida, 8'hC0);
      ciclos(4);
      chk("l2r_e0", ifa.saida, 8'hE0);
      ciclos(4);
      chk("l2r_f0", ifa.saida, 8'hF0);

      // mode change at count 3
      ciclos(3);
      modo = 2'b01; sdir = 1'b1;
      ciclos(1);
      chk("chg_no_step", ifa.saida, 8'hF0);
      chk("chg_no_pulse", {7'd0, ifa.pulso_passo}, 8'h00);
      ciclos(3);
      chk("chg_wait", ifa.saida, 8'hF0);
      ciclos(1);
      chk("chg_first_step", ifa.saida, 8'hE1);

      // rotation request
      modo = 2'b00; valores = 8'h81;
      ciclos(1);
      modo = 2'b01; rot = 1'b1; sdir = 1'b0; sesq = 1'b0;
      ciclos(5);
`ifdef ROTACAO_EN
      chk("rot_r2l_1", ifa.saida, 8'h03);
      ciclos(4);
      chk("rot_r2l_2", ifa.saida, 8'h06);
      modo = 2'b10;
      ciclos(5);
      chk("rot_l2r", ifa.saida, 8'h03);
`else
      chk("rot_r2l_1", ifa.saida, 8'h02);
      ciclos(4);
      chk("rot_r2l_2", ifa.saida, 8'h04);
      modo = 2'b10;
      ciclos(5);
      chk("rot_l2r", ifa.saida, 8'h02);
`endif

      // random traffic, modo kept sticky so steps actually happen
      for (int i = 0; i < 3000; i++) begin
         rst_n   = ($urandom_range(63) != 0);
         if ($urandom_range(15) == 0) modo = 2'($urandom_range(3));
         hab     = ($urandom_range(4) != 0);
         valores = 8'($urandom);
         sdir    = 1'($urandom);
         sesq    = 1'($urandom);
         rot     = 1'($urandom);
         ciclos(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/registrador_deslocamento_universal.md
Name: registrador_deslocamento_universal

Overview:
- Clocked, parametrised universal shift register. Successor of the combinational mode multiplexer.
- The same 2-bit mode code selects load, right-to-left shift, left-to-right shift or hold, and the register applies it.
- A built-in prescaler paces the shifts so LED patterns move at a visible rate.
- Drives the LED bank directly from its output register.

Parameters:
- LARGURA, 8, register width in bits (>= 2).
- DIVISOR, 4, clock cycles per shift step (>= 1; 1 = shift every enabled cycle).
- LARG_CONT, $clog2(DIVISOR) min 1, prescaler counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- habilitar  input  1  enables prescaler and shifting; 0 = freeze (load still works).
- modo  input  2  00 definir_valores (load), 01 direita_para_esquerda, 10 esquerda_para_direita, 11 hold.
- valores  input  LARGURA  parallel load data.
- serial_dir  input  1  bit entering at LSB on direita_para_esquerda.
- serial_esq  input  1  bit entering at MSB on esquerda_para_direita.
- rotacionar  input  1  rotate instead of serial fill (used only with ROTACAO_EN).
- saida  output  LARGURA  register contents.
- pulso_passo  output  1  one-cycle pulse in the cycle after a shift is applied.

Behaviour:
- Reset (rst_n=0 at rising clk): saida=0, pulso_passo=0, prescaler count=0, stored previous mode=11. Reset has priority over everything, including mid-step.
- Prescaler: while habilitar=1 and modo is 01 or 10, count increments each cycle. tick = (count==DIVISOR-1); on tick, count wraps to 0.
- DIVISOR=1: tick every enabled cycle.
- habilitar=0: count holds, no tick.
- modo 00 or 11: count forced to 0.
- Mode change: if modo differs from the registered previous mode, count is cleared that cycle and no shift occurs. The first shift after a change comes DIVISOR cycles later.
- modo 00: saida <= valores on every clock edge, regardless of habilitar or tick. pulso_passo stays 0.
- modo 01, on tick: saida <= {saida[LARGURA-2:0], serial_dir}.
- modo 10, on tick: saida <= {serial_esq, saida[LARGURA-1:1]}.
- modo 11: saida holds.
- pulso_passo: registered. It is 1 in the cycle after each applied shift, otherwise 0. Latency from tick to visible saida change is 1 edge, coincident with pulso_passo.
- No X propagation: unknown modo values hold state in simulation.

Optional Feature:
- Macro ROTACAO_EN.
- Defined: when rotacionar=1, modo 01 fills the LSB with saida[LARGURA-1], and modo 10 fills the MSB with saida[0]. The serial inputs are ignored. When rotacionar=0, serial fill applies.
- Undefined: rotacionar is ignored and no rotation logic is synthesised. Behaviour is serial fill only.

Decomposition:
- Shared package holds localparam mode codes MODO_DEFINIR=2'b00, MODO_DIR_ESQ=2'b01, MODO_ESQ_DIR=2'b10, MODO_MANTER=2'b11. The mux and the future pattern controller use the same codes.
- One sub-module: divisor_passo. It contains the prescaler counter, mode-change clear and tick generation, with ports clk, rst_n, habilitar, modo, tick.
- The shift datapath stays in the top module.

Test Plan (LARGURA=8, DIVISOR=4 unless noted):
- Reset: rst_n=0 for 2 cycles with modo=00, valores=8'hFF -> saida=8'h00, pulso_passo=0. After release, the next edge gives saida=8'hFF.
- Load then right-to-left: load 8'b0000_0001, then modo=01, serial_dir=0, habilitar=1 -> saida becomes 8'b0000_0010 exactly 4 cycles after the mode change. Then 0000_0100 at 4 cycles later, with one pulso_passo per step.
- Left-to-right with fill: load 8'h80, modo=10, serial_esq=1 -> sequence C0, E0, F0, each 4 cycles apart.
- Freeze: in modo=01, drop habilitar for 6 cycles at count=2 -> saida and count hold. After re-enable, the shift occurs after 1 more cycle.
- Mode change mid-count: switch 01->10 at count=3 -> no shift that cycle, count=0, first right shift 4 cycles later. Also DIVISOR=1: a shift occurs every enabled cycle.
- ROTACAO_EN build: saida=8'h81, modo=01, rotacionar=1 -> 8'h03, 8'h06. Then modo=10 -> after 4 cycles 8'h03 with the MSB filled from bit0. Non-ROTACAO build, same stimulus -> the serial_dir value is shifted in instead.
